// File: rtl/column_buffer.sv
// column_buffer: ping-pong store of per-column trace results, served to the display
// as a 2-stage per-pixel wall/side/texture lookup.
module column_buffer #(
  parameter int COL_BASE  = 64,
  parameter int COLS      = 512,
  parameter int HALF_H    = 240,
  parameter int WALL_HALF = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store,
  input  logic [9:0]  column,
  input  logic        side,
  input  logic [15:0] vdist,
  input  logic [5:0]  tex,
  input  logic        frame_end,
  input  logic        rd_en,
  input  logic [9:0]  h,
  input  logic [9:0]  v,
  output logic        wall,
  output logic        wall_side,
  output logic [5:0]  wall_tex,
  output logic        disp_bank,
  output logic        have_frame,
  output logic [7:0]  stale_count,
  output logic        oob_err
);
  localparam int AW = $clog2(COLS);
  typedef enum logic {FILL, FULL} state_t;
  state_t       state_q;
  logic [22:0]  mem_q [2*COLS];
  logic [22:0]  ent_q;
  logic [10:0]  wr_count_q, wr_count_d, col_off, h_off;
  logic         disp_bank_q, have_frame_q, oob_q, wr_hit, rd_hit;
  logic [7:0]   stale_q, dy_d, dy_q;
  logic         vld1_q, in1_q, hit2;
  logic [23:0]  prod;
  logic         wall_q, side_q;
  logic [5:0]   tex_q;
  // Offsets below COL_BASE wrap to large values, so one compare covers both bounds.
  assign col_off    = 11'(column) - 11'(COL_BASE);
  assign h_off      = 11'(h) - 11'(COL_BASE);
  assign wr_hit     = col_off < 11'(COLS);
  assign rd_hit     = h_off < 11'(COLS);
  assign wr_count_d = (store && wr_hit && state_q == FILL) ? wr_count_q + 11'd1 : wr_count_q;
  assign dy_d       = (v >= 10'(HALF_H)) ? 8'(v - 10'(HALF_H)) : 8'(10'(HALF_H - 1) - v);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wr_count_q   <= '0;
      disp_bank_q  <= 1'b0;
      have_frame_q <= 1'b0;
      stale_q      <= '0;
      oob_q        <= 1'b0;
    end else begin
      oob_q <= oob_q | (store & ~wr_hit);
      if (frame_end) begin
        wr_count_q <= '0;
        state_q    <= FILL;
        if (wr_count_d == 11'(COLS)) begin
          disp_bank_q  <= ~disp_bank_q;
          have_frame_q <= 1'b1;
        end else begin
          stale_q <= stale_q + 8'd1;
        end
      end else begin
        wr_count_q <= wr_count_d;
        state_q    <= (wr_count_d == 11'(COLS)) ? FULL : FILL;
      end
    end
  end
  // A same-cycle store lands in the pre-swap back bank.
  always_ff @(posedge clk) begin
    if (store && wr_hit) mem_q[{~disp_bank_q, col_off[AW-1:0]}] <= {side, vdist, tex};
    ent_q <= mem_q[{disp_bank_q, h_off[AW-1:0]}];
  end
  assign prod = 24'(dy_q) * 24'(ent_q[21:6]);
  assign hit2 = vld1_q & in1_q & have_frame_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      vld1_q <= 1'b0;
      in1_q  <= 1'b0;
      dy_q   <= '0;
      wall_q <= 1'b0;
      side_q <= 1'b0;
      tex_q  <= '0;
    end else begin
      vld1_q <= rd_en;
      in1_q  <= rd_hit;
      dy_q   <= dy_d;
      wall_q <= hit2 && (prod < 24'(WALL_HALF << 9));
      side_q <= hit2 & ent_q[22];
      tex_q  <= hit2 ? ent_q[5:0] : 6'd0;
    end
  end
  assign wall        = wall_q;
  assign wall_side   = side_q;
  assign wall_tex    = tex_q;
  assign disp_bank   = disp_bank_q;
  assign have_frame  = have_frame_q;
  assign stale_count = stale_q;
  assign oob_err     = oob_q;
endmodule

// File: tb/tb_column_buffer.sv
// tb_column_buffer: directed stimulus with a read scoreboard for column_buffer.
module tb_column_buffer;
  logic        clk = 1'b0, reset = 1'b1, store = 1'b0, side = 1'b0, frame_end = 1'b0, rd_en = 1'b0;
  logic [9:0]  column = '0, h = '0, v = '0;
  logic [15:0] vdist = '0;
  logic [5:0]  tex = '0;
  logic        wall, wall_side, disp_bank, have_frame, oob_err;
  logic [5:0]  wall_tex;
  logic [7:0]  stale_count;
  int          n_cmp = 0, n_err = 0;
  logic        pend = 1'b0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  column_buffer dut (
    .clk(clk), .reset(reset), .store(store), .column(column), .side(side), .vdist(vdist),
    .tex(tex), .frame_end(frame_end), .rd_en(rd_en), .h(h), .v(v), .wall(wall),
    .wall_side(wall_side), .wall_tex(wall_tex), .disp_bank(disp_bank), .have_frame(have_frame),
    .stale_count(stale_count), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e;
    string t;
    @(posedge clk);
    #1;
    if (pend) begin
      if (exp_q.size() == 0) chk("sb_empty", 16'(exp_q.size()), 16'd1);
      else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".wall"}, 16'(wall), 16'(e[7]));
        chk({t, ".side"}, 16'(wall_side), 16'(e[6]));
        chk({t, ".tex"}, 16'(wall_tex), 16'(e[5:0]));
      end
    end
    pend = rd_en && !reset;
  endtask

  task automatic wr(input int c, input logic s, input logic [15:0] vd, input logic [5:0] tx);
    store = 1'b1; column = 10'(c); side = s; vdist = vd; tex = tx;
    step();
    store = 1'b0;
  endtask

  task automatic fill(input int n, input int c0, input logic s, input logic [15:0] vd);
    for (int i = 0; i < n; i++) wr(c0 + i, s, vd, 6'(c0 + i));
  endtask

  task automatic fe();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic rd(input int hh, input int vv, input logic ew, input logic es, input logic [5:0] et,
                    input string tag);
    rd_en = 1'b1; h = 10'(hh); v = 10'(vv);
    exp_q.push_back({ew, es, et});
    tag_q.push_back(tag);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst.disp_bank", 16'(disp_bank), 16'd0);
    chk("rst.have_frame", 16'(have_frame), 16'd0);
    chk("rst.stale", 16'(stale_count), 16'd0);
    chk("rst.oob", 16'(oob_err), 16'd0);
    chk("rst.wall", 16'(wall), 16'd0);
    chk("rst.tex", 16'(wall_tex), 16'd0);
    fill(512, 64, 1'b1, 16'h0200);
    fe();
    chk("f1.disp_bank", 16'(disp_bank), 16'd1);
    chk("f1.have_frame", 16'(have_frame), 16'd1);
    rd(64, 240, 1'b1, 1'b1, 6'd0, "h64v240");
    rd(64, 367, 1'b1, 1'b1, 6'd0, "v367");
    rd(64, 368, 1'b0, 1'b1, 6'd0, "v368");
    rd(64, 112, 1'b1, 1'b1, 6'd0, "v112");
    rd(64, 111, 1'b0, 1'b1, 6'd0, "v111");
    rd(63, 240, 1'b0, 1'b0, 6'd0, "h63");
    rd(576, 240, 1'b0, 1'b0, 6'd0, "h576");
    rd(575, 240, 1'b1, 1'b1, 6'd63, "h575");
    step();
    fill(300, 64, 1'b0, 16'h0200);
    fe();
    chk("stale.disp_bank", 16'(disp_bank), 16'd1);
    chk("stale.count", 16'(stale_count), 16'd1);
    rd(64, 240, 1'b1, 1'b1, 6'd0, "stale.h64");
    rd(300, 240, 1'b1, 1'b1, 6'd44, "stale.h300");
    step();
    fill(511, 64, 1'b0, 16'h0200);
    wr(600, 1'b0, 16'h0200, 6'd0);
    chk("oob.set", 16'(oob_err), 16'd1);
    fe();
    chk("oob.no_swap", 16'(disp_bank), 16'd1);
    chk("oob.stale", 16'(stale_count), 16'd2);
    chk("oob.sticky", 16'(oob_err), 16'd1);
    fill(511, 64, 1'b0, 16'h0200);
    store = 1'b1; column = 10'd575; side = 1'b0; vdist = 16'h0100; tex = 6'd63; frame_end = 1'b1;
    step();
    store = 1'b0; frame_end = 1'b0;
    chk("same.disp_bank", 16'(disp_bank), 16'd0);
    chk("same.stale", 16'(stale_count), 16'd2);
    rd(575, 495, 1'b1, 1'b0, 6'd63, "same.dy255");
    rd(64, 368, 1'b0, 1'b0, 6'd0, "same.h64v368");
    rd(100, 240, 1'b1, 1'b0, 6'd36, "same.h100");
    step();
    fill(200, 64, 1'b1, 16'h0200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2.disp_bank", 16'(disp_bank), 16'd0);
    chk("rst2.have_frame", 16'(have_frame), 16'd0);
    chk("rst2.stale", 16'(stale_count), 16'd0);
    chk("rst2.oob", 16'(oob_err), 16'd0);
    fill(512, 64, 1'b1, 16'h0200);
    rd(64, 240, 1'b0, 1'b0, 6'd0, "noframe.h64");
    rd(200, 300, 1'b0, 1'b0, 6'd0, "noframe.h200");
    step();
    fe();
    chk("f2.disp_bank", 16'(disp_bank), 16'd1);
    chk("f2.have_frame", 16'(have_frame), 16'd1);
    rd(64, 240, 1'b1, 1'b1, 6'd0, "f2.h64");
    rd(130, 250, 1'b1, 1'b1, 6'd2, "f2.h130");
    step();
    chk("sb_left", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
